// File: rtl/alsu_arb_pkg.sv
// Shared types for the ALSU arbiter: command layout, FSM states, opcodes
// and the illegal-command helper used when ALSU_ARB_ILLEGAL_CHECK_EN is defined.
package alsu_arb_pkg;

    localparam int ALSU_CMD_W = 17;

    localparam logic [2:0] OP_OR     = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MULT   = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    // One full ALSU command, MSB first exactly as it appears on req_cmd
    typedef struct packed {
        logic [2:0]        opcode;
        logic signed [2:0] a;
        logic signed [2:0] b;
        logic [1:0]        cin;
        logic              red_op_a;
        logic              red_op_b;
        logic              bypass_a;
        logic              bypass_b;
        logic              direction;
        logic              serial_in;
    } alsu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Opcodes 6/7 do not exist; reduction flags only make sense for OR/XOR
    function automatic logic cmd_is_illegal(input alsu_cmd_t cmd);
        logic bad_op;
        logic bad_red;
        bad_op  = (cmd.opcode == 3'd6) || (cmd.opcode == 3'd7);
        bad_red = (cmd.red_op_a || cmd.red_op_b) &&
                  (cmd.opcode != OP_OR) && (cmd.opcode != OP_XOR);
        return bad_op || bad_red;
    endfunction

endpackage

// File: rtl/alsu_arbiter_rr.sv
// Combinational round-robin grant: searches from the slot after the last
// winner, wrapping once around the ring. Returns one-hot and encoded grant.
module alsu_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    // Walk the ring starting just after ptr; the first valid slot wins
    always_comb begin
        int               slot_s;
        logic [IDX_W-1:0] idx_s;
        logic             hit_s;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        slot_s    = 0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            slot_s       = int'(ptr) + off;
            slot_s       = (slot_s >= NUM_REQ) ? (slot_s - NUM_REQ) : slot_s;
            idx_s        = IDX_W'(slot_s);
            hit_s        = req_valid[idx_s] & ~grant_any;
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? idx_s : grant_idx;
            grant_any    = grant_any | hit_s;
        end
    end

endmodule

// File: rtl/alsu_arbiter.sv
// Shares one registered ALSU between NUM_REQ requesters. One command is in
// flight at a time: accept -> drive ALSU pins -> wait out the pipeline ->
// return the sampled result tagged with the requester index.
// Optional build macro: ALSU_ARB_ILLEGAL_CHECK_EN rejects illegal commands
// (rsp_err=1, rsp_data=0, ALSU pins untouched) without issuing them.
module alsu_arbiter
    import alsu_arb_pkg::*;
#(
    parameter int  NUM_REQ      = 2,
    parameter int  ALSU_LATENCY = 2,
    parameter int  CMD_W        = ALSU_CMD_W,
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDX_W-1:0]         rsp_id,
    output logic signed [5:0]        rsp_data,
    output logic                     rsp_err,
    output logic [2:0]               alsu_opcode,
    output logic signed [2:0]        alsu_A,
    output logic signed [2:0]        alsu_B,
    output logic [1:0]               alsu_cin,
    output logic                     alsu_red_op_A,
    output logic                     alsu_red_op_B,
    output logic                     alsu_bypass_A,
    output logic                     alsu_bypass_B,
    output logic                     alsu_direction,
    output logic                     alsu_serial_in,
    input  logic signed [5:0]        alsu_out
);

    localparam int CNT_W = $clog2(ALSU_LATENCY + 1);

    arb_state_e         state_r;
    arb_state_e         state_nxt_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               grant_any_s;
    alsu_cmd_t          cmd_sel_s;
    logic               illegal_s;

    alsu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_valid (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    assign cmd_sel_s = req_cmd[grant_idx_s * CMD_W +: CMD_W];

`ifdef ALSU_ARB_ILLEGAL_CHECK_EN
    assign illegal_s = cmd_is_illegal(cmd_sel_s);
`else
    assign illegal_s = 1'b0;
`endif

    // Accept strobe: only the granted requester, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (rst && (state_r == IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state decode for the issue/wait/respond sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    state_nxt_s = illegal_s ? RESP : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: pointer, ALSU pin registers, pipeline counter and response fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r          <= IDX_W'(NUM_REQ - 1);
            cnt_r          <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_data       <= 6'sd0;
            rsp_err        <= 1'b0;
            alsu_opcode    <= 3'd0;
            alsu_A         <= 3'sd0;
            alsu_B         <= 3'sd0;
            alsu_cin       <= 2'd0;
            alsu_red_op_A  <= 1'b0;
            alsu_red_op_B  <= 1'b0;
            alsu_bypass_A  <= 1'b0;
            alsu_bypass_B  <= 1'b0;
            alsu_direction <= 1'b0;
            alsu_serial_in <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        ptr_r   <= grant_idx_s;
                        rsp_id  <= grant_idx_s;
                        rsp_err <= illegal_s;
                        if (illegal_s) begin
                            rsp_data  <= 6'sd0;
                            rsp_valid <= 1'b1;
                        end else begin
                            // Pins load on the accept edge so the ALSU captures them at the end of ISSUE
                            alsu_opcode    <= cmd_sel_s.opcode;
                            alsu_A         <= cmd_sel_s.a;
                            alsu_B         <= cmd_sel_s.b;
                            alsu_cin       <= cmd_sel_s.cin;
                            alsu_red_op_A  <= cmd_sel_s.red_op_a;
                            alsu_red_op_B  <= cmd_sel_s.red_op_b;
                            alsu_bypass_A  <= cmd_sel_s.bypass_a;
                            alsu_bypass_B  <= cmd_sel_s.bypass_b;
                            alsu_direction <= cmd_sel_s.direction;
                            alsu_serial_in <= cmd_sel_s.serial_in;
                        end
                    end
                end
                ISSUE: begin
                    cnt_r <= CNT_W'(ALSU_LATENCY);
                end
                WAIT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        rsp_data  <= alsu_out;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_arbiter.sv
// Randomized + directed bench for alsu_arbiter with a behavioural two-stage
// ALSU stand-in and a cycle-level reference model of the arbitration contract.
`timescale 1ns/1ps
module tb_alsu_arbiter;
    import alsu_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int LAT     = 2;
    localparam int IDX_W   = 1;
    localparam int CW      = 17;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*CW-1:0]  req_cmd;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDX_W-1:0]       rsp_id;
    logic signed [5:0]      rsp_data;
    logic                   rsp_err;
    logic [2:0]             alsu_opcode;
    logic signed [2:0]      alsu_A;
    logic signed [2:0]      alsu_B;
    logic [1:0]             alsu_cin;
    logic                   alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic                   alsu_direction, alsu_serial_in;
    logic signed [5:0]      alsu_out;

    always #5 clk = ~clk;

    alsu_arbiter #(.NUM_REQ(NUM_REQ), .ALSU_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
        .alsu_cin(alsu_cin), .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_direction(alsu_direction), .alsu_serial_in(alsu_serial_in), .alsu_out(alsu_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit tb_illegal(input alsu_cmd_t c);
        return (c.opcode >= 3'd6) || ((c.red_op_a || c.red_op_b) && (c.opcode >= 3'd2));
    endfunction

    // What an ALSU returns for a command (shift/rotate never generated here)
    function automatic logic signed [5:0] ref_alsu(input alsu_cmd_t c);
        int a, b, r;
        a = c.a;
        b = c.b;
        if (tb_illegal(c))     r = 0;
        else if (c.bypass_a)   r = a;
        else if (c.bypass_b)   r = b;
        else begin
            case (c.opcode)
                3'd0:    r = c.red_op_a ? int'(c.a != 3'd0) : (c.red_op_b ? int'(c.b != 3'd0) : (a | b));
                3'd1:    r = c.red_op_a ? int'(^c.a) : (c.red_op_b ? int'(^c.b) : (a ^ b));
                3'd2:    r = a + b + int'(c.cin);
                3'd3:    r = a * b;
                default: r = 0;
            endcase
        end
        return 6'(r);
    endfunction

    function automatic alsu_cmd_t pins_now();
        alsu_cmd_t p;
        p.opcode = alsu_opcode;  p.a = alsu_A;  p.b = alsu_B;  p.cin = alsu_cin;
        p.red_op_a = alsu_red_op_A;  p.red_op_b = alsu_red_op_B;
        p.bypass_a = alsu_bypass_A;  p.bypass_b = alsu_bypass_B;
        p.direction = alsu_direction;  p.serial_in = alsu_serial_in;
        return p;
    endfunction

    // ALSU stand-in: input register then output register
    alsu_cmd_t stub_in_r;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_in_r <= '0;
            alsu_out  <= 6'sd0;
        end else begin
            stub_in_r <= pins_now();
            alsu_out  <= ref_alsu(stub_in_r);
        end
    end

    function automatic alsu_cmd_t mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                     input logic [1:0] cin, input logic reda);
        alsu_cmd_t c;
        c = '0;
        c.opcode = op;  c.a = a;  c.b = b;  c.cin = cin;  c.red_op_a = reda;
        return c;
    endfunction

    function automatic alsu_cmd_t rand_cmd(input bit legal);
        alsu_cmd_t c;
        int k;
        k = $urandom_range(0, 5);
        c.opcode    = (k < 4) ? 3'(k) : 3'(k + 2);
        c.a         = 3'($urandom);
        c.b         = 3'($urandom);
        c.cin       = 2'($urandom);
        c.red_op_a  = ($urandom_range(0, 7) == 0);
        c.red_op_b  = ($urandom_range(0, 7) == 0);
        c.bypass_a  = ($urandom_range(0, 7) == 0);
        c.bypass_b  = ($urandom_range(0, 7) == 0);
        c.direction = 1'($urandom);
        c.serial_in = 1'($urandom);
        if (legal && tb_illegal(c)) begin
            c.opcode = 3'd2;  c.red_op_a = 1'b0;  c.red_op_b = 1'b0;
        end
        return c;
    endfunction

    // Reference model state
    int                 cyc = 0;
    bit                 m_busy = 0;
    int                 m_rsp_cyc = 0;
    int                 m_ptr = NUM_REQ - 1;
    int                 m_accept_cyc = 0;
    logic [IDX_W-1:0]   m_id = '0;
    logic signed [5:0]  m_data = 6'sd0;
    logic               m_err = 1'b0;
    alsu_cmd_t          m_pins = '0;
    int                 n_accept = 0;
    int                 n_rsp = 0;
    int                 last_grant = -1;

    // Stimulus state
    logic [NUM_REQ-1:0] want = '0;
    alsu_cmd_t          cmd_q [NUM_REQ];
    bit                 rand_mode = 0;
    logic               dir_rsp_ready = 1'b1;

    // Last observation
    bit                 obs_rv;
    int                 obs_cyc;
    logic [IDX_W-1:0]   obs_id;
    logic signed [5:0]  obs_data;
    logic               obs_err;
    logic [NUM_REQ-1:0] obs_ready;

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rand_mode) begin
                if (!want[i] && ($urandom_range(0, 2) == 0)) begin
                    cmd_q[i] = rand_cmd(1'b0);
                    want[i]  = 1'b1;
                end
                req_valid[i] = want[i] && ($urandom_range(0, 3) != 0);
            end else begin
                req_valid[i] = want[i];
            end
            req_cmd[i*CW +: CW] = cmd_q[i];
        end
        rsp_ready = rand_mode ? ($urandom_range(0, 2) != 0) : dir_rsp_ready;
    endtask

    // One clock: check at negedge against the model, advance model, drive after posedge
    task automatic step();
        logic [NUM_REQ-1:0] exp_ready;
        bit found, exp_rv, ill;
        int g, s, acc_idx;
        @(negedge clk);
        exp_ready = '0;  found = 0;  g = 0;  acc_idx = -1;  ill = 0;
        if (!m_busy) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                s = (m_ptr + off) % NUM_REQ;
                if (!found && req_valid[s]) begin found = 1; g = s; end
            end
        end
        if (found) exp_ready[g] = 1'b1;
        exp_rv = m_busy && (cyc >= m_rsp_cyc);
        obs_rv = rsp_valid;  obs_cyc = cyc;  obs_id = rsp_id;
        obs_data = rsp_data;  obs_err = rsp_err;  obs_ready = req_ready;
        check("req_ready", req_ready, exp_ready);
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            check("rsp_id", rsp_id, m_id);
            check("rsp_data", rsp_data, m_data);
            check("rsp_err", rsp_err, m_err);
        end
        check("alsu_pins", pins_now(), m_pins);
        if (found) begin
            acc_idx = g;  m_ptr = g;  m_id = IDX_W'(g);  m_busy = 1;
            last_grant = g;  n_accept++;  m_accept_cyc = cyc;
`ifdef ALSU_ARB_ILLEGAL_CHECK_EN
            ill = tb_illegal(cmd_q[g]);
`endif
            if (ill) begin
                m_rsp_cyc = cyc + 1;  m_err = 1'b1;  m_data = 6'sd0;
            end else begin
                m_rsp_cyc = cyc + LAT + 2;  m_err = 1'b0;
                m_data = ref_alsu(cmd_q[g]);  m_pins = cmd_q[g];
            end
        end else if (exp_rv && rsp_ready) begin
            m_busy = 0;  n_rsp++;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (acc_idx >= 0) want[acc_idx] = 1'b0;
        drive();
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        int k;
        k = 0;  obs_rv = 0;
        while (!obs_rv && k < 40) begin step(); k++; end
        if (!obs_rv) check({tag, "_timeout"}, 32'd0, 32'd1);
        lat = obs_cyc - m_accept_cyc;
    endtask

    task automatic wait_accept(input string tag);
        int k, n0;
        k = 0;  n0 = n_accept;
        while (n_accept == n0 && k < 40) begin step(); k++; end
        if (n_accept == n0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((m_busy || want != '0) && k < 200) begin step(); k++; end
        if (m_busy || want != '0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        alsu_cmd_t t6_prev;
        logic [IDX_W-1:0] s_id;
        logic signed [5:0] s_data;
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) cmd_q[i] = '0;
        req_valid = '0;  req_cmd = '0;  rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, pins_now()}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive();

        // 1: reset in the middle of WAIT discards the command; pointer restarts at 0
        cmd_q[0] = mk(3'd2, 3'd3, 3'd2, 2'd0, 1'b0);
        cmd_q[1] = rand_cmd(1'b1);
        want = 2'b11;
        drive();
        wait_accept("t1_acc");
        check("t1_first_grant", last_grant, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("t1_async_clear", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, pins_now()}, 32'd0);
        m_busy = 0;  m_ptr = NUM_REQ - 1;  m_pins = '0;  n_accept = n_rsp;
        cmd_q[0] = mk(3'd2, 3'd3, 3'd2, 2'd1, 1'b0);
        want[0] = 1'b1;
        drive();
        #1;
        check("t1_ready_in_reset", req_ready, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // 2: ADD 3+2+1 after reset: requester 0 wins over pending 1
        wait_rsp("t2", lat);
        check("t2_latency", lat, 32'd4);
        check("t2_id", obs_id, 32'd0);
        check("t2_data", obs_data, 32'd6);
        check("t2_err", obs_err, 32'd0);
        drain("t2_drain");

        // 3: both held valid; last winner was 1, so grants run 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!want[i]) begin cmd_q[i] = rand_cmd(1'b1); want[i] = 1'b1; end
            end
            drive();
            wait_accept("t3_acc");
            check("t3_rr_grant", last_grant, k % 2);
        end
        drain("t3_drain");

        // 4: backpressure holds the response and blocks new grants
        dir_rsp_ready = 1'b0;
        cmd_q[0] = rand_cmd(1'b1);  cmd_q[1] = rand_cmd(1'b1);
        want = 2'b11;
        drive();
        wait_rsp("t4", lat);
        s_id = obs_id;  s_data = obs_data;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_hold_valid", obs_rv, 32'd1);
            check("t4_hold_id", obs_id, s_id);
            check("t4_hold_data", obs_data, s_data);
            check("t4_no_grant", obs_ready, 32'd0);
        end
        dir_rsp_ready = 1'b1;
        drive();
        drain("t4_drain");

        // 5: MULT -4*-4 and OR reduction of A=100
        cmd_q[0] = mk(3'd3, 3'b100, 3'b100, 2'd0, 1'b0);
        want[0] = 1'b1;
        drive();
        wait_rsp("t5_mult", lat);
        check("t5_mult_data", obs_data, 32'd16);
        drain("t5_drain1");
        cmd_q[0] = mk(3'd0, 3'b100, 3'b000, 2'd0, 1'b1);
        t6_prev = cmd_q[0];
        want[0] = 1'b1;
        drive();
        wait_rsp("t5_or", lat);
        check("t5_or_data", obs_data, 32'd1);
        drain("t5_drain2");

        // 6: opcode 7
        cmd_q[1] = mk(3'd7, 3'd1, 3'd2, 2'd0, 1'b0);
        want[1] = 1'b1;
        drive();
        wait_rsp("t6", lat);
`ifdef ALSU_ARB_ILLEGAL_CHECK_EN
        check("t6_latency", lat, 32'd1);
        check("t6_err", obs_err, 32'd1);
        check("t6_pins_kept", pins_now(), t6_prev);
`else
        check("t6_latency", lat, 32'd4);
        check("t6_err", obs_err, 32'd0);
        check("t6_pins_issued", pins_now(), mk(3'd7, 3'd1, 3'd2, 2'd0, 1'b0));
`endif
        check("t6_data", obs_data, 32'd0);
        drain("t6_drain");

        // Random traffic against the model
        rand_mode = 1;
        for (int k = 0; k < 800; k++) step();
        rand_mode = 0;
        dir_rsp_ready = 1'b1;
        drive();
        drain("rand_drain");
        check("no_lost_request", n_rsp, n_accept);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
